// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one full-subtractor cell, a borrow flop and a
// three-state sequencer with a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bw_q, borrow_q;

    logic             x, y, d, bwn, last;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        x     = sa_q[0];
        y     = sb_q[0];
        d     = x ^ y ^ bw_q;
        bwn   = (~x & y) | (~(x ^ y) & bw_q);
        last  = (cnt_q == CW'(WIDTH - 1));
        res_d = {d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q  <= a;
                        sb_q  <= b;
                        bw_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    res_q <= res_d;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    bw_q  <= bwn;
                    cnt_q <= cnt_q + CW'(1);
                    // Result becomes visible only once all bits are in.
                    if (last) begin
                        diff_q   <= res_d;
                        borrow_q <= bwn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
endmodule
